// File: rtl/fp_norm_round.sv
// Post-add normalise/round stage of the binary32 adder: shifts the raw sum one bit
// per clock until the hidden bit is set, rounds to nearest-even and packs the result.
module fp_norm_round #(
  parameter int          EXP_W       = 10,
  parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [27:0]             in_mant,
  input  logic                    in_nan,
  input  logic                    in_inf,
  output logic [31:0]             result,
  output logic                    done,
  output logic                    busy,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact
);

  // Two guard bits of exponent headroom so a +1 carry or 26 left shifts cannot wrap.
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'(255);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(0);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] NORM  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] PACK  = 3'd4;

  logic [2:0]           r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [31:0]          r_result;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_inexact;

  logic                 r_sign;
  logic signed [XW-1:0] r_exp;
  logic [27:0]          r_mant;
  logic                 r_nan;
  logic                 r_inf;
  logic [22:0]          r_frac;

  logic [24:0]          w_round;
  logic                 w_zero;
  logic                 w_special;

  function automatic logic [24:0] round_rne(input logic [27:0] m);
    logic inc;
    inc = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[26:3]} + {24'd0, inc};
  endfunction

  assign w_round   = round_rne(r_mant);
  assign w_zero    = (r_mant == 28'd0);
  assign w_special = r_nan | r_inf | w_zero;

  // Control: sequencing, handshake, flags and the packed result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= 32'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
            r_state     <= CHECK;
          end
        end
        CHECK: begin
          if (w_special)           r_state <= PACK;
          else if (r_mant[27] || r_mant[26]) r_state <= ROUND;
          else                     r_state <= NORM;
        end
        NORM: begin
          if (r_mant[25]) r_state <= ROUND;
        end
        ROUND: begin
          r_inexact <= |r_mant[2:0];
          r_state   <= PACK;
        end
        PACK: begin
          if (r_nan) begin
            r_result <= NAN_PATTERN;
          end else if (r_inf) begin
            r_result <= {r_sign, 8'hFF, 23'd0};
          end else if (w_zero) begin
            r_result <= {r_sign, 31'd0};
          end else if (r_exp >= EXP_MAX) begin
            r_result   <= {r_sign, 8'hFF, 23'd0};
            r_overflow <= 1'b1;
            r_inexact  <= 1'b1;
          end else if (r_exp <= EXP_MIN) begin
            r_result    <= {r_sign, 31'd0};
            r_underflow <= 1'b1;
          end else begin
            r_result <= {r_sign, r_exp[7:0], r_frac};
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture, normalising shifts and rounding.
  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: begin
        if (start) begin
          r_sign <= in_sign;
          r_exp  <= XW'(in_exp);
          r_mant <= in_mant;
          r_nan  <= in_nan;
          r_inf  <= in_inf;
        end
      end
      CHECK: begin
        // Carry out of the add: fold the bit shifted out into sticky.
        if (!w_special && r_mant[27]) begin
          r_mant <= {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
          r_exp  <= r_exp + EXP_ONE;
        end
      end
      NORM: begin
        r_mant <= r_mant << 1;
        r_exp  <= r_exp - EXP_ONE;
      end
      ROUND: begin
        if (w_round[24]) begin
          r_exp  <= r_exp + EXP_ONE;
          r_frac <= 23'd0;
        end else begin
          r_frac <= w_round[22:0];
        end
      end
      default: ;
    endcase
  end

  assign result    = r_result;
  assign done      = r_done;
  assign busy      = r_busy;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign inexact   = r_inexact;

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed corner cases followed by random operands,
// each compared with an arithmetic rounding model.
module tb_fp_norm_round;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [27:0]       in_mant;
  logic              in_nan;
  logic              in_inf;
  logic [31:0]       result;
  logic              done;
  logic              busy;
  logic              overflow;
  logic              underflow;
  logic              inexact;

  int n_cmp = 0;
  int n_err = 0;

  fp_norm_round #(.EXP_W(10), .NAN_PATTERN(32'h7FC00000)) dut (
    .clk(clk), .reset(reset), .start(start), .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_nan(in_nan), .in_inf(in_inf), .result(result),
    .done(done), .busy(busy), .overflow(overflow), .underflow(underflow),
    .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: round the significand as an integer, dropping bits below the top 24.
  function automatic void model(input bit s, input int e, input logic [27:0] m,
                                input bit nan, input bit inf,
                                output logic [31:0] r, output logic ov,
                                output logic uf, output logic ix, output int lat);
    int     p, d, ee;
    longint sig, rem, half;
    ov = 1'b0; uf = 1'b0; ix = 1'b0;
    lat = 2;
    if (nan)      begin r = 32'h7FC00000;          return; end
    if (inf)      begin r = {s, 8'hFF, 23'd0};     return; end
    if (m == 0)   begin r = {s, 31'd0};            return; end
    p = 27;
    while (!m[p]) p--;
    lat = (p >= 26) ? 3 : 3 + (26 - p);
    ee  = e + p - 26;
    d   = p - 23;
    sig = longint'(m);
    rem = 0;
    if (d <= 0) begin
      sig = sig << (-d);
    end else begin
      rem  = sig & ((longint'(1) << d) - 1);
      half = longint'(1) << (d - 1);
      sig  = sig >> d;
      if (rem > half || (rem == half && sig[0])) sig++;
    end
    ix = (rem != 0);
    if (sig == (longint'(1) << 24)) begin
      sig = sig >> 1;
      ee++;
    end
    if (ee >= 255) begin
      r = {s, 8'hFF, 23'd0}; ov = 1'b1; ix = 1'b1;
    end else if (ee <= 0) begin
      r = {s, 31'd0}; uf = 1'b1;
    end else begin
      r = {s, ee[7:0], sig[22:0]};
    end
  endfunction

  task automatic run_op(input bit s, input int e, input logic [27:0] m,
                        input bit nan, input bit inf, input bit poke);
    logic [31:0] er;
    logic        eov, euf, eix;
    int          elat, lat;
    bit          got;
    model(s, e, m, nan, inf, er, eov, euf, eix, elat);
    @(negedge clk);
    in_sign = s; in_exp = 10'(e); in_mant = m; in_nan = nan; in_inf = inf;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("done_low_after_start", {31'd0, done}, 32'd0);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin got = 1'b1; lat = i; break; end
      chk("busy_in_flight", {31'd0, busy}, 32'd1);
      if (poke && i == 1) begin
        start = 1'b1; in_mant = ~m; in_exp = 10'(e + 7); in_sign = ~s;
      end
      if (poke && i == 2) start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("result",    result, er);
      chk("overflow",  {31'd0, overflow},  {31'd0, eov});
      chk("underflow", {31'd0, underflow}, {31'd0, euf});
      chk("inexact",   {31'd0, inexact},   {31'd0, eix});
      chk("latency",   32'(lat), 32'(elat));
      chk("busy_at_done", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int          sel, p, e, dones;
    logic [31:0] tmp;
    logic [27:0] m;
    reset = 1'b1; start = 1'b1; in_sign = 1'b0; in_exp = '0; in_mant = 28'h4000000;
    in_nan = 1'b0; in_inf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'd0, busy}, 32'd0);
    chk("reset_done",   {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags",  {29'd0, overflow, underflow, inexact}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 127, 28'd1 << 26, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 127, 28'd1 << 27, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 130, 28'd1 << 23, 1'b0, 1'b0, 1'b1);
    run_op(1'b0, 127, (28'd1 << 26) | 28'd4,  1'b0, 1'b0, 1'b0);
    run_op(1'b0, 127, (28'd1 << 26) | 28'd12, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 254, 28'h7FFFFFC, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 3,   28'd1 << 22, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 127, 28'd1 << 26, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 50,  28'd0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 90,  28'd5, 1'b0, 1'b1, 1'b0);
    run_op(1'b1, 200, 28'd1, 1'b0, 1'b0, 1'b1);

    // Abort a long normalisation with reset; no done may follow.
    @(negedge clk);
    in_sign = 1'b0; in_exp = 10'd140; in_mant = 28'd1 << 10; in_nan = 1'b0; in_inf = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy",   {31'd0, busy}, 32'd0);
    chk("abort_done",   {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 19);
      p   = $urandom_range(0, 27);
      tmp = ($urandom & ((32'd1 << p) - 1)) | (32'd1 << p);
      if (sel == 3) tmp = (tmp & ~32'h7) | 32'h4;
      m   = tmp[27:0];
      if (sel == 0) m = 28'd0;
      e = int'($urandom_range(0, 420)) - 60;
      run_op(1'($urandom), e, m, sel == 1, sel == 2, sel == 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
